// File: rtl/imm_encode.sv
// imm_encode: inverse of the immediate extender.
// Takes a 32-bit constant and emits the shortest sequence of (imm16, eop)
// beats that the extender (plus an ori for the low half) rebuilds exactly:
//   eop 00 sext, 01 zext, 10 lui (imm<<16), 11 sext<<2.
// One beat when a single extend mode fits, otherwise lui(hi) then ori(lo).
// Optional feature macro: IMM_SHIFT_EN enables the one-beat eop=11 form for
// word-aligned constants within sext18 range; when undefined eop=11 is never
// produced and such constants take the two-beat path.
// Handshake: valid/ready on both sides, one constant in flight at a time.

module imm_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_last,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
`ifdef IMM_SHIFT_EN
    localparam logic [1:0] EOP_SHL2 = 2'b11;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [15:0] cap_lo;      // low half kept for the second (ori) beat

    // Classification result for the constant currently on in_data.
    logic        cls_one;
    logic [15:0] cls_imm;
    logic [1:0]  cls_eop;

    // Pick the first extend mode that rebuilds in_data; default is the split form.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cls_one = 1'b0;
        cls_imm = in_data[31:16];
        cls_eop = EOP_LUI;
        if ((&in_data[31:15]) || (~|in_data[31:15])) begin
            // Sign-extension of the low half reproduces the upper bits.
            cls_one = 1'b1;
            cls_imm = in_data[15:0];
            cls_eop = EOP_SEXT;
        end else if (in_data[31:16] == 16'h0000) begin
            cls_one = 1'b1;
            cls_imm = in_data[15:0];
            cls_eop = EOP_ZEXT;
        end else if (in_data[15:0] == 16'h0000) begin
            cls_one = 1'b1;
            cls_imm = in_data[31:16];
            cls_eop = EOP_LUI;
`ifdef IMM_SHIFT_EN
        end else if ((in_data[1:0] == 2'b00) &&
                     ((&in_data[31:17]) || (~|in_data[31:17]))) begin
            // Word-aligned and bit 17 sign-extends into the top: sext(imm)<<2.
            cls_one = 1'b1;
            cls_imm = in_data[17:2];
            cls_eop = EOP_SHL2;
`endif
        end else begin
            // Two beats: lui with the high half now, ori with the low half next.
            cls_one = 1'b0;
            cls_imm = in_data[31:16];
            cls_eop = EOP_LUI;
        end
    end

    // Encoder FSM with registered handshake and beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the captured low half is reset along with the control state;
            // it is a single small register, so a defined value costs nothing and
            // keeps the outputs free of X after reset.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_imm   <= 16'h0000;
            out_eop   <= EOP_SEXT;
            out_last  <= 1'b0;
            split_cnt <= '0;
            cap_lo    <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_lo    <= in_data[15:0];
                        out_imm   <= cls_imm;
                        out_eop   <= cls_eop;
                        out_last  <= cls_one;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= cls_one ? ONE : HI;
                    end
                end
                ONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HI: begin
                    if (out_ready) begin
                        out_imm  <= cap_lo;
                        out_eop  <= EOP_ZEXT;
                        out_last <= 1'b1;
                        if (split_cnt != CNT_MAX) begin
                            split_cnt <= split_cnt + CNT_ONE;
                        end
                        state    <= LO;
                    end
                end
                LO: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
